// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the device
// over the shared PS2_CLK/PS2_DAT pair, driving both lines open-drain through
// drive-low enables. One frame is: inhibit (clock held low), request-to-send
// (data low = start bit), then the device clocks out 8 data bits LSB first,
// odd parity and stop, and finally returns an ACK bit.
//
// Ports:
//   clk             system clock
//   resetn          asynchronous active-low reset
//   ps2c_in         sampled PS2 clock line
//   ps2d_in         sampled PS2 data line
//   tx_data[7:0]    command byte, latched when tx_start is accepted
//   tx_start        one-cycle request, accepted only while idle
//   ps2c_drive_low  1 = pull PS2 clock low, 0 = release
//   ps2d_drive_low  1 = pull PS2 data low, 0 = release
//   tx_busy         high while a transfer is in progress
//   tx_done         one-cycle pulse when a transfer ends
//   tx_err          valid with tx_done: 1 = no ACK or timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    // One counter serves both the inhibit interval and the edge timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic [9:0]            frame_reg, frame_next;
    logic                  ack_ok_reg, ack_ok_next;
    logic                  c_low_reg, c_low_next;
    logic                  d_low_reg, d_low_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  err_reg, err_next;

    // Clock deglitch: the filtered level only changes once the whole
    // window agrees, so short spikes on the line are absorbed.
    logic [FILTER_LEN-1:0] shift_reg;
    logic                  filt_reg, filt_next;
    logic                  fall;

    always_comb begin
        filt_next = filt_reg;
        if (&shift_reg) begin
            filt_next = 1'b1;
        end else if (~|shift_reg) begin
            filt_next = 1'b0;
        end
    end

    assign fall = filt_reg & ~filt_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg <= '1;
            filt_reg  <= 1'b1;
        end else begin
            shift_reg <= {shift_reg[FILTER_LEN-2:0], ps2c_in};
            filt_reg  <= filt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        frame_next   = frame_reg;
        ack_ok_next  = ack_ok_reg;
        d_low_next   = d_low_reg;

        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    state_next   = INHIBIT;
                    cnt_next     = '0;
                    bit_cnt_next = 4'd0;
                    frame_next   = {1'b1, ~^tx_data, tx_data};
                    ack_ok_next  = 1'b0;
                end
            end
            INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    state_next = RTS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RTS: begin
                // Data stays low into SEND: that is the start bit.
                state_next = SEND;
                cnt_next   = '0;
            end
            SEND, ACK, WAIT_IDLE: begin
                cnt_next = fall ? '0 : cnt_reg + CNT_W'(1);
                if (fall && state_reg == SEND) begin
                    // Frame bits go out on falls 1..10; the stop bit (1)
                    // releases the data line.
                    d_low_next   = ~frame_reg[0];
                    frame_next   = {1'b1, frame_reg[9:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd9) begin
                        state_next = ACK;
                    end
                end else if (fall && state_reg == ACK) begin
                    ack_ok_next = ~ps2d_in;
                    state_next  = WAIT_IDLE;
                end
                if (state_reg == WAIT_IDLE && filt_reg && ps2d_in) begin
                    state_next = DONE;
                end else if (!fall && cnt_reg == TIMEOUT_LAST) begin
                    state_next  = DONE;
                    ack_ok_next = 1'b0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Line drives and status are derived from the next state so that
        // every output comes straight from a flop.
        c_low_next = (state_next == INHIBIT) || (state_next == RTS);
        if (state_next == IDLE || state_next == INHIBIT || state_next == DONE) begin
            d_low_next = 1'b0;
        end else if (state_next == RTS) begin
            d_low_next = 1'b1;
        end
        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
        err_next  = (state_next == DONE) && !ack_ok_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= 4'd0;
            frame_reg   <= '0;
            ack_ok_reg  <= 1'b0;
            c_low_reg   <= 1'b0;
            d_low_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            frame_reg   <= frame_next;
            ack_ok_reg  <= ack_ok_next;
            c_low_reg   <= c_low_next;
            d_low_reg   <= d_low_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign ps2c_drive_low = c_low_reg;
    assign ps2d_drive_low = d_low_reg;
    assign tx_busy        = busy_reg;
    assign tx_done        = done_reg;
    assign tx_err         = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Bench for ps2_host_tx: a device model clocks frames out of the host over
// open-drain lines, recording the bits it sees; expected bytes, parity and
// error flags come from the protocol rules.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int FLT  = 8;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err;
    logic       dev_c_low = 1'b0, dev_d_low = 1'b0, glitch = 1'b0;
    logic       ps2c_in, ps2d_in;

    // Wired-AND lines with pull-ups; glitch flips the sampled clock.
    assign ps2c_in = (~(ps2c_drive_low | dev_c_low)) ^ glitch;
    assign ps2d_in = ~(ps2d_drive_low | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(FLT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .ps2c_drive_low(ps2c_drive_low),
        .ps2d_drive_low(ps2d_drive_low),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int t_fall = 0;
    int d0_g = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (resetn && tx_done === 1'b1) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [7:0] data;
        int         nfalls;
        bit         ack;
        bit         glt;
        bit         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Odd parity: parity bit makes the total count of ones odd.
    function automatic logic model_parity(input logic [7:0] d);
        return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic half_period(input bit glt);
        for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            glitch = glt && (i >= 15) && (i < 18);
        end
        glitch = 1'b0;
    endtask

    // Device: drives nfalls clock pulses, samples data just before each rise.
    task automatic bfm(input int nfalls, input bit ack, input bit glt, output logic [9:0] bits);
        bits = '1;
        half_period(glt);
        for (int k = 1; k <= nfalls; k++) begin
            dev_c_low = 1'b1;
            t_fall = cyc;
            half_period(glt);
            if (k <= 10) bits[k-1] = ps2d_in;
            dev_c_low = 1'b0;
            if (k == 10) dev_d_low = ack;
            if (k == 11) dev_d_low = 1'b0;
            if (k < nfalls) half_period(glt);
        end
    endtask

    task automatic watch_request();
        int inh;
        int rts;
        inh = 0;
        while (ps2c_drive_low && !ps2d_drive_low && inh < 1000) begin
            inh++;
            @(negedge clk);
        end
        rts = 0;
        while (ps2c_drive_low && ps2d_drive_low && rts < 1000) begin
            rts++;
            @(negedge clk);
        end
        chk("inhibit_len", inh, INH);
        chk("rts_len", rts, 1);
        chk("send_lines", {ps2c_drive_low, ps2d_drive_low}, 2'b01);
    endtask

    task automatic start_txn(input logic [7:0] data);
        d0_g = done_cnt;
        @(negedge clk);
        tx_data = data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = ~data;
        chk("busy_after_start", tx_busy, 1);
        watch_request();
    endtask

    // Runs the device side and returns on the negedge where tx_done is seen.
    task automatic finish_txn(input logic [7:0] data, input int nfalls, input bit ack,
                              input bit glt, input bit exp_err, input string tag);
        logic [9:0] bits;
        bit seen;
        int elapsed;
        bfm(nfalls, ack, glt, bits);
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (tx_done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        elapsed = cyc - t_fall;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_err"}, tx_err, exp_err);
        chk({tag, "_busy_at_done"}, tx_busy, 0);
        chk({tag, "_lines_at_done"}, {ps2c_drive_low, ps2d_drive_low}, 2'b00);
        if (nfalls >= 11) begin
            chk({tag, "_byte"}, bits[7:0], data);
            chk({tag, "_parity"}, bits[8], model_parity(data));
            chk({tag, "_stop"}, bits[9], 1);
        end else begin
            chk({tag, "_timeout_latency"}, (elapsed >= TMO) && (elapsed <= TMO + FLT + 4), 1);
        end
        $display("txn %s data=%02h falls=%0d ack=%0b glitch=%0b err=%0b rx=%02h",
                 tag, data, nfalls, ack, glt, tx_err, bits[7:0]);
    endtask

    task automatic post_txn(input string tag);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - d0_g, 1);
        chk({tag, "_idle_busy"}, tx_busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start_txn(v.data);
        finish_txn(v.data, v.nfalls, v.ack, v.glt, v.exp_err, tag);
        post_txn(tag);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vec_t rv;
        logic [9:0] bits;
        int busy_cycles;
        int d0;

        vecs[0] = '{data: 8'hED, nfalls: 11, ack: 1'b1, glt: 1'b0, exp_err: 1'b0};
        vecs[1] = '{data: 8'h01, nfalls: 11, ack: 1'b0, glt: 1'b0, exp_err: 1'b1};
        vecs[2] = '{data: 8'hFF, nfalls: 4,  ack: 1'b1, glt: 1'b0, exp_err: 1'b1};
        vecs[3] = '{data: 8'hA5, nfalls: 11, ack: 1'b1, glt: 1'b1, exp_err: 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err}, 5'b0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outputs", {ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err}, 5'b0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Request while busy is ignored.
        start_txn(8'hF4);
        fork
            finish_txn(8'hF4, 11, 1'b1, 1'b0, 1'b0, "busy_req");
            begin
                repeat (300) @(negedge clk);
                tx_data = 8'h55;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        post_txn("busy_req");
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_busy) busy_cycles++;
        end
        chk("busy_req_no_restart", busy_cycles, 0);

        // Start in the DONE cycle is ignored; in the following IDLE cycle it is accepted.
        start_txn(8'h3C);
        finish_txn(8'h3C, 11, 1'b1, 1'b0, 1'b0, "chain_a");
        tx_data = 8'hC3;
        tx_start = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored", tx_busy, 0);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = 8'h00;
        chk("start_in_idle_accepted", tx_busy, 1);
        d0_g = done_cnt;
        watch_request();
        finish_txn(8'hC3, 11, 1'b1, 1'b0, 1'b0, "chain_b");
        post_txn("chain_b");

        // Reset at fall 5 releases the lines at once with no done pulse.
        start_txn(8'h96);
        bfm(4, 1'b1, 1'b0, bits);
        half_period(1'b0);
        d0 = done_cnt;
        dev_c_low = 1'b1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_lines", {ps2c_drive_low, ps2d_drive_low}, 2'b00);
        chk("rst_mid_busy", tx_busy, 0);
        repeat (5) @(negedge clk);
        dev_c_low = 1'b0;
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        run_vec(vecs[0], "after_rst");

        // Random bytes, ACK behaviour and glitching against the protocol model.
        for (int i = 0; i < 8; i++) begin
            rv.data    = 8'($urandom);
            rv.nfalls  = 11;
            rv.ack     = 1'($urandom_range(0, 1));
            rv.glt     = 1'($urandom_range(0, 1));
            rv.exp_err = !rv.ack;
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the same PS2_CLK/PS2_DAT pair that the keyboard receiver listens on. It drives the lines as open-drain through drive-low enables and follows the device-clocked host-to-device frame: inhibit, request-to-send, start, 8 data bits LSB first, odd parity, stop, device ACK. While this block is busy, the keyboard receiver is gated off.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles PS2 clock is held low before request-to-send (120 us at 50 MHz); minimum 1.
TIMEOUT_CYCLES, 750000, max clk cycles allowed between the release of the clock and the first device falling edge, and between any two later falling edges (15 ms).
FILTER_LEN, 8, length of the ps2c_in deglitch shift register.

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
ps2c_in  in  1  sampled PS2 clock line
ps2d_in  in  1  sampled PS2 data line
tx_data  in  8  command byte; latched on accepted tx_start
tx_start  in  1  one-cycle request; accepted only when tx_busy=0
ps2c_drive_low  out  1  1 = pull PS2 clock low; 0 = release (high-Z)
ps2d_drive_low  out  1  1 = pull PS2 data low; 0 = release (high-Z)
tx_busy  out  1  high from the cycle after acceptance until the cycle of tx_done
tx_done  out  1  one-cycle pulse when a transfer ends (success or failure)
tx_err  out  1  valid with tx_done: 1 = no ACK or timeout; 0 otherwise

Behaviour:
- Reset (async, resetn=0): all outputs 0, both lines released, FSM=IDLE, filtered clock state=1, counters 0. Asserting reset mid-transfer releases both lines immediately, with no done pulse.
- Clock filter: FILTER_LEN-bit shift of ps2c_in. Filtered state goes to 1 on all-ones and to 0 on all-zeros; otherwise it holds. fall = filtered 1->0 transition, one-cycle pulse.
- Frame shift register: {stop=1, parity=~^tx_data, tx_data} is latched on acceptance; bit counter is 4 bits.
- IDLE: lines released. tx_start → latch, tx_busy=1, go to INHIBIT, counter=0.
- INHIBIT: ps2c_drive_low=1. After INHIBIT_CYCLES cycles, go to RTS.
- RTS: for exactly 1 cycle, ps2c_drive_low=1 and ps2d_drive_low=1 (start bit). Next cycle go to SEND: release clock, keep data low, timeout counter=0.
- SEND: on each fall, present the next frame bit as ps2d_drive_low = ~bit.
  - fall 1..8: data bits 0..7.
  - fall 9: parity.
  - fall 10: stop (release data).
  - Then go to ACK.
- ACK: on the next fall, sample ps2d_in. 0 = ack_ok, 1 = nack. Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock=1 and ps2d_in=1, then go to DONE.
- DONE: tx_done=1 and tx_err=~ack_ok for one cycle, tx_busy=0, lines released, go to IDLE.
- Timeout: in SEND, ACK and WAIT_IDLE the counter increments every cycle and clears on each fall. Reaching TIMEOUT_CYCLES → release both lines and go to DONE with tx_err=1.
- tx_start while tx_busy=1 is ignored; tx_data changes after acceptance have no effect.
- A fall during INHIBIT or RTS is ignored.
- tx_start in the DONE cycle is ignored; tx_start in the following IDLE cycle is accepted.
- ps2c_drive_low and ps2d_drive_low are registered outputs, so there is no glitching.

Test Plan:
All scenarios use INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, and a device BFM clocking at 40-clk half-periods.
- Send 0xED: clock held low for 20 cycles, then RTS, then bits 1,0,1,1,0,1,1,1 on falls 1..8, parity 1, stop released. BFM pulls ACK low → tx_done with tx_err=0; tx_busy deasserts in the same cycle.
- Send 0x01 (parity 0) with the BFM withholding ACK (data high at fall 11) → tx_done with tx_err=1.
- Send 0xFF, with the BFM stopping clocking after fall 4 → after 2000 cycles, lines released and tx_done with tx_err=1; return to IDLE.
- Pulse tx_start with 0x55 while busy sending 0xF4 → the frame carries 0xF4 only, with exactly one tx_done.
- Assert resetn=0 at fall 5 → both drive_low outputs go 0 asynchronously, with no tx_done. After release, a new 0xED transfer completes with tx_err=0.
- Inject 3-cycle glitches on ps2c_in during SEND → no extra bit shift; the byte received by the BFM equals the byte sent.
